err_log_fifo: RTL
=================

# err_log_fifo

Error-word sink that sits directly downstream of the error manager. It completes the 4-phase req/ack handshake on each 32-bit error word and buffers the words in a show-ahead FIFO. A register/readout interface drains the FIFO, and a saturating counter records words dropped because the FIFO was full.

## Interface

Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).

Ports:
- `clk`, in, 1: system clock. One clock domain; every signal is synchronous to `clk`.
- `rst`, in, 1: reset. Synchronous and active-high.
- `err_req`, in, 1: error word available from upstream. Level signal.
- `err_data`, in, 32: error word. Stable whenever `err_req` is high.
- `err_ack`, out, 1: acknowledge to upstream. Registered.
- `rd_req`, in, 1: single-cycle pop of the FIFO head.
- `rd_data`, out, 32: FIFO head (show-ahead). Reads 0 when empty.
- `empty`, out, 1: FIFO empty.
- `full`, out, 1: FIFO full.
- `count`, out, DEPTH_LOG2+1: number of stored words, 0 to 2^DEPTH_LOG2.
- `ovf_cnt`, out, 16: dropped-word counter. Saturating.
- `ovf_clr`, in, 1: single-cycle clear of `ovf_cnt`.

## Operation

**Reset.** While `rst` is high:
- `err_ack`=0, `count`=0, `empty`=1, `full`=0, `ovf_cnt`=0.
- Read and write pointers=0; FSM=`S_IDLE`.
- FIFO memory is not reset.

**Handshake FSM** (2 states).
- `S_IDLE`: `err_ack`=0. If `err_req`=1:
  - If the FIFO is not full, or `rd_req` is high in the same cycle, write `err_data` at the write pointer and increment the write pointer (wraps modulo depth).
  - Otherwise drop the word and increment `ovf_cnt`.
  - In both cases set `err_ack`<=1 and go to `S_ACK`.
- `S_ACK`:
  - Hold `err_ack`=1 while `err_req`=1.
  - When `err_req`=0, set `err_ack`<=0 and go to `S_IDLE`.
- Undefined state: go to `S_IDLE` with `err_ack`<=0.
- Exactly one capture per request. A new request can be seen only after `err_ack` has been low for at least one cycle. Upstream detects the ack falling edge, so this spacing is mandatory.

**FIFO.**
- `rd_req` while empty is ignored: no pointer or count change.
- Write and pop in the same cycle leave `count` unchanged and move both pointers.
- A write into a full FIFO is accepted only when a concurrent pop frees the slot.
- `count` = written − popped. `full` = (`count` == 2^DEPTH_LOG2). `empty` = (`count` == 0). `full` and `empty` are registered or derived from registered `count`.
- `rd_data` = memory at the read pointer, gated to 0 when `empty`=1.

**Overflow counter.**
- Increments by 1 on each dropped word and saturates at 0xFFFF.
- `ovf_clr` alone sets it to 0.
- `ovf_clr` together with a drop in the same cycle sets it to 1.

## Timing

- `err_req` sampled high at edge n (in `S_IDLE`): at edge n+1 `err_ack`=1, `count` has updated, and `empty` has updated.
- On a first write into an empty FIFO, `rd_data` is valid in the cycle after edge n+1.
- `err_req` sampled low at edge m (in `S_ACK`): `err_ack`=0 after edge m+1.
- Minimum handshake period is 4 cycles with a 1-cycle-latency upstream.
- `rd_req` at edge k: the next entry, or 0 if the FIFO is now empty, is on `rd_data` after edge k+1.
- Reset mid-handshake: `err_ack` drops at the next edge and the FSM returns to `S_IDLE`. A word already written is lost along with the FIFO contents. Upstream must be reset with this block.

## Test plan

- **Reset values:** assert `rst` for 3 cycles with `err_req`=1 → `err_ack`=0, `count`=0, `empty`=1, `ovf_cnt`=0, `rd_data`=0 throughout.
- **Single handshake:** `err_req`=1 with `err_data`=0xDEAD0001, dropped after `err_ack` rises → exactly one write; `count`=1, `rd_data`=0xDEAD0001. `err_ack` high for as long as `err_req` stays high, then low one cycle after `err_req` falls.
- **Fill and overflow:** 18 back-to-back handshakes with data 0..17 and no reads → `count`=16, `full`=1, `ovf_cnt`=2. Popping 16 times returns 0..15 in order, then `empty`=1.
- **Concurrent write and pop on a full FIFO:** `rd_req` in the same cycle the 17th word is sampled → word accepted, `count` stays 16, `ovf_cnt` unchanged.
- **Overflow counter edges:** force 65536 drops → `ovf_cnt`=0xFFFF, not wrapping. `ovf_clr` coincident with a drop → `ovf_cnt`=1. `rd_req` on an empty FIFO → no state change.
- **Reset mid-handshake:** `rst` pulsed while in `S_ACK` → `err_ack`=0 at the next edge, `count`=0. Holding `err_req` high after reset produces one new capture.

Source files
------------

// File: rtl/err_log_fifo.sv
// Error-word sink: completes the 4-phase req/ack handshake with the error manager,
// buffers words in a show-ahead FIFO and counts words dropped while full.
module err_log_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned OVF_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  err_req,
    input  logic [31:0]           err_data,
    output logic                  err_ack,
    input  logic                  rd_req,
    output logic [31:0]           rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic [OVF_W-1:0]      ovf_cnt,
    input  logic                  ovf_clr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned DW    = 32;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            ack_d;
    logic            capture_c;
    logic            wr_en_c;
    logic            pop_c;
    logic            drop_c;
    logic [CW-1:0]   count_d;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [DW-1:0]   mem [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = err_req ? S_ACK : S_IDLE;
            S_ACK:   state_d = err_req ? S_ACK : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: one capture per request, taken only in S_IDLE
    always_comb begin
        ack_d     = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                capture_c = err_req;
                ack_d     = err_req;
            end
            S_ACK: begin
                ack_d = err_req;
            end
            default: begin
                ack_d     = 1'b0;
                capture_c = 1'b0;
            end
        endcase
    end

    // A full FIFO still accepts a word when the same cycle's pop frees a slot
    assign pop_c   = rd_req && !empty;
    assign wr_en_c = capture_c && (!full || rd_req);
    assign drop_c  = capture_c && full && !rd_req;
    assign count_d = count + CW'(wr_en_c) - CW'(pop_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ack <= 1'b0;
        end else begin
            err_ack <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CW'(DEPTH));
        end
    end

    // Storage is intentionally left unreset
    always_ff @(posedge clk) begin
        if (!rst && wr_en_c) begin
            mem[wr_ptr] <= err_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Saturating drop counter; a clear coinciding with a drop leaves it at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (drop_c) begin
            if (ovf_clr) begin
                ovf_cnt <= OVF_W'(1);
            end else if (ovf_cnt != OVF_MAX) begin
                ovf_cnt <= ovf_cnt + OVF_W'(1);
            end
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end
    end

endmodule
